// File: rtl/alu_share_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_pkg
// Shared definitions for the ALU sharing controller: FSM state encoding,
// ALU opcode constants, statistics counter width and a saturating increment
// helper used by the optional grant counters.
// -----------------------------------------------------------------------------
package alu_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int STAT_W = 16;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl_if
// Bundles the requester handshakes, the ALU operand/result bus and the
// response channel of the ALU sharing controller.
//   slave  : controller view (takes requests, drives ALU and responses)
//   master : environment view (requesters, ALU instance, response consumer)
// -----------------------------------------------------------------------------
interface alu_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_op;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic                     alu_op;
  logic [WIDTH-1:0]         alu_result;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result
  );

endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request found
// scanning upward from ptr, wrapping at N.
//   req    : request vector
//   ptr    : index with highest priority this cycle (must be < N)
//   grant  : one-hot grant, zero when no request is asserted
//   winner : encoded index of the granted request
//   found  : at least one request asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          found
);

  // One spare bit so ptr + offset cannot overflow before the wrap subtract.
  logic [IW:0] idx_s;
  logic        hit_s;

  // Scan N positions starting at ptr and keep the first hit.
  always_comb begin
    grant  = '0;
    winner = '0;
    hit_s  = 1'b0;
    idx_s  = '0;
    for (int i = 0; i < N; i++) begin
      idx_s = {1'b0, ptr} + (IW+1)'(i);
      if (idx_s >= (IW+1)'(N)) begin
        idx_s = idx_s - (IW+1)'(N);
      end else begin
        idx_s = idx_s;
      end
      if (!hit_s && req[idx_s[IW-1:0]]) begin
        hit_s                 = 1'b1;
        grant[idx_s[IW-1:0]]  = 1'b1;
        winner                = idx_s[IW-1:0];
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign found = hit_s;

endmodule

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
// Round-robin controller sharing one registered ADD/SUB ALU between NUM_REQ
// requesters. One operation in flight: IDLE (accept) -> ISSUE (ALU computes)
// -> WAIT (capture result) -> RESP (hold until consumed).
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   bus        : alu_share_ctrl_if.slave (requests, ALU bus, response)
//   stat_sel   : (ALU_SHARE_STATS_EN only) requester whose count is read
//   stat_count : (ALU_SHARE_STATS_EN only) saturating grant count
// Optional build macro: ALU_SHARE_STATS_EN adds per-requester grant counters.
// -----------------------------------------------------------------------------
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  alu_share_ctrl_if.slave   bus
`ifdef ALU_SHARE_STATS_EN
  ,
  input  logic [ID_W-1:0]   stat_sel,
  output logic [STAT_W-1:0] stat_count
`endif
);

  state_e             state_r;
  state_e             next_state_s;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [ID_W-1:0]    next_ptr_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    win_id_s;
  logic               found_s;
  logic               accept_s;

  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic               op_op_r;
  logic [ID_W-1:0]    op_id_r;
  logic               rsp_valid_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic [WIDTH-1:0]   rsp_result_r;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req    (bus.req_valid),
    .ptr    (rr_ptr_r),
    .grant  (grant_s),
    .winner (win_id_s),
    .found  (found_s)
  );

  assign accept_s   = (state_r == ST_IDLE) && found_s;
  assign next_ptr_s = (win_id_s == ID_W'(NUM_REQ-1)) ? ID_W'(0) : win_id_s + ID_W'(1);

  // Ready is also masked while reset is held so no requester sees a grant
  // that the held-off state register could never act on.
  assign bus.req_ready = ((state_r == ST_IDLE) && reset) ? grant_s : '0;

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: next_state_s = ST_WAIT;
      ST_WAIT:  next_state_s = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, round-robin pointer, latched operation and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      op_a_r       <= '0;
      op_b_r       <= '0;
      op_op_r      <= OP_ADD;
      op_id_r      <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_result_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        rr_ptr_r <= next_ptr_s;
        op_a_r   <= bus.req_a[win_id_s*WIDTH +: WIDTH];
        op_b_r   <= bus.req_b[win_id_s*WIDTH +: WIDTH];
        op_op_r  <= bus.req_op[win_id_s];
        op_id_r  <= win_id_s;
      end
      // The ALU result registered at the end of ISSUE is visible during WAIT.
      if (state_r == ST_WAIT) begin
        rsp_valid_r  <= 1'b1;
        rsp_id_r     <= op_id_r;
        rsp_result_r <= bus.alu_result;
      end else if ((state_r == ST_RESP) && bus.rsp_ready) begin
        rsp_valid_r  <= 1'b0;
      end
    end
  end

  // ALU operands are held from the latch so they stay put until the next accept.
  assign bus.alu_a      = op_a_r;
  assign bus.alu_b      = op_b_r;
  assign bus.alu_op     = op_op_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;

`ifdef ALU_SHARE_STATS_EN
  logic [STAT_W-1:0] cnt_r [NUM_REQ];

  // Per-requester saturating grant counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept_s && (win_id_s == ID_W'(i))) begin
          cnt_r[i] <= sat_inc(cnt_r[i]);
        end
      end
    end
  end

  assign stat_count = cnt_r[stat_sel];
`endif

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Round-robin controller that shares the single 8-bit ADD/SUB execution unit between NUM_REQ requesters.
- Accepts one operation at a time over per-requester valid/ready handshakes and drives the ALU operand/opcode inputs.
- Waits out the ALU's one-cycle registered latency, then returns the result with the requester ID over a valid/ready response channel.
- Sits between the requesting front-end blocks and the ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width; must match the ALU.
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing.
- req_op  in  NUM_REQ  per-requester opcode: 0=ADD, 1=SUB.
- alu_a  out  WIDTH  operand A to the ALU.
- alu_b  out  WIDTH  operand B to the ALU.
- alu_op  out  1  opcode to the ALU.
- alu_result  in  WIDTH  registered ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  requester ID of the response.
- rsp_result  out  WIDTH  result.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0.
  - alu_a=0, alu_b=0, alu_op=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning from rr_ptr upward with wrap at NUM_REQ.
  - req_ready is combinational: req_ready[winner]=1 only in IDLE; all zeros in any other state or when no request is valid.
  - On the accepting edge: latch req_a/req_b/req_op of the winner and its ID into internal regs; rr_ptr <= (winner+1) mod NUM_REQ; go to ISSUE.
  - No request valid -> stay IDLE; rr_ptr unchanged.
- ISSUE: go to WAIT after 1 cycle. The ALU registers its result at the end of this cycle.
- alu_a/alu_b/alu_op:
  - Driven from the latched regs at all times, not just in ISSUE.
  - Hold their values until the next accept.
  - Reset value is 0.
- WAIT: capture alu_result into rsp_result and the latched ID into rsp_id; go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_result and rsp_id are stable while rsp_valid=1 and rsp_ready=0.
  - rsp_valid & rsp_ready -> rsp_valid=0, go to IDLE.
  - No new accept occurs in the handshake cycle; the next accept is possible in the following cycle.
- Latency: accept edge at cycle T -> rsp_valid=1 in cycle T+3, regardless of backpressure before the accept.
- Throughput: at most one operation per 4 cycles when rsp_ready is held 1.
- Arithmetic is done entirely by the ALU: modulo 2^WIDTH, no carry/borrow flag. The controller never modifies the result.
- Requesters must hold req_valid and their payload stable until they see req_ready. Dropping req_valid early is legal: the request is simply not taken.
- Reset mid-operation: any in-flight operation is discarded, no response is produced, and rr_ptr returns to 0.

Optional Feature:
- Macro: ALU_SHARE_STATS_EN.
- Defined:
  - Adds one 16-bit grant counter per requester, incremented on each accept of that requester.
  - Counters saturate at 0xFFFF and reset to 0.
  - Adds ports stat_sel (in, ID_W) and stat_count (out, 16). stat_count is the combinational read of counter[stat_sel].
- Undefined: no counters and no stat ports. Functional behaviour is otherwise identical.

Decomposition:
- Shared package alu_share_pkg holds:
  - the FSM state enum (2-bit: IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - opcode constants OP_ADD=1'b0, OP_SUB=1'b1;
  - STAT_W=16.
- One sub-module is natural: rr_arbiter.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and encoded winner ID; purely combinational.
  - Instantiated once; reusable by other shared resources.

Test Plan:
- Single request:
  - Stimulus: req 0 with a=8'h05, b=8'h03, op=ADD; rsp_ready=1.
  - Required: req_ready[0] high for the accept cycle; rsp_valid at T+3 with rsp_id=0, rsp_result=8'h08; alu_op=0 during ISSUE.
- Wrap-around:
  - SUB a=8'h02, b=8'h05 -> rsp_result=8'hFD.
  - ADD a=8'hFF, b=8'h01 -> rsp_result=8'h00.
- Fairness:
  - Stimulus: all 4 req_valid held high continuously, rsp_ready=1.
  - Required: grant order 0,1,2,3,0,1; 8 responses in 32 cycles with IDs in that order.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles during RESP while other requesters are valid.
  - Required: rsp_result and rsp_id held stable; req_ready stays 0; the next grant goes to (previous winner + 1) one cycle after the handshake.
- Reset mid-operation:
  - Stimulus: assert reset in WAIT.
  - Required: all outputs go to 0 immediately (async); after release, no stale response appears and the next grant with all requesters valid goes to ID 0.
- ALU_SHARE_STATS_EN:
  - Stimulus: 3 accepts for requester 2, 1 accept for requester 0; stat_sel=2.
  - Required: stat_count=3; stat_sel=1 gives 0.
